// File: rtl/dec_pkg.sv
// Shared types and helpers for the registered one-hot decoder.
// Used by onehot_decoder_hs and dec_timeout_ctr.
package dec_pkg;

  // Default width of the encoded index (4 one-hot lines).
  localparam int DEF_IDX_W = 2;

  // Widest index the onehot() helper supports; callers size-cast the result.
  localparam int MAX_IDX_W = 8;
  localparam int MAX_OUT_W = 2 ** MAX_IDX_W;

  // Width of the grant-age counter; holds any timeout in 1..255.
  localparam int TO_CNT_W = 8;

  // IDLE: waiting for a code. DRIVE: one-hot line held until ack or expiry.
  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } dec_state_t;

  // Returns 1 << idx at the widest supported width; callers truncate to OUT_W.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_OUT_W-1:0] res;
    res      = '0;
    res[idx] = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/dec_timeout_ctr.sv
// Grant-age counter for the one-hot decoder.
// clr_i restarts the count at zero, en_i advances it by one per cycle.
// expire_o is a combinational pulse during the TO_CYC-th enabled cycle, so the
// owner can release the grant on the following clock edge.
// Only instantiated when DEC_TIMEOUT_EN is defined.
module dec_timeout_ctr
  import dec_pkg::*;
#(
  parameter int TO_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TO_CNT_W-1:0] LAST = TO_CNT_W'(TO_CYC - 1);

  logic [TO_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over enable, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TO_CNT_W'(1);
    end
  end

  // Count register, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count equals the number of earlier unacked cycles in this grant.
  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/onehot_decoder_hs.sv
// Registered N-to-2^N one-hot decoder with a valid/ready input and an ack-held
// output. Turns an arbitrated request index back into a per-line grant.
// Optional feature macro: DEC_TIMEOUT_EN (grant timeout and sticky timeout_err).
//
// Handshake: a code transfers on any rising edge where in_valid && in_ready.
// in_ready is high only in IDLE, so the producer must hold in_valid/in_code/in_v
// stable until it sees in_ready; the grant is then held on dec_out/dec_valid
// until the consumer pulses dec_ack (or, when enabled, the grant times out).
module onehot_decoder_hs
  import dec_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int TO_CYC = 8,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_W-1:0]      in_code,
  input  logic                  in_v,
  output logic [2**IDX_W-1:0]   dec_out,
  output logic                  dec_valid,
  input  logic                  dec_ack,
  output logic                  none_seen,
  output logic [CNT_W-1:0]      dec_cnt,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  localparam int OUT_W = 2 ** IDX_W;

  dec_state_t       state_q, state_d;
  logic [OUT_W-1:0] dec_q, dec_d;
  logic             valid_q, valid_d;
  logic             none_q, none_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hs;
  logic             expire;
  logic [OUT_W-1:0] code_onehot;

  assign in_ready    = (state_q == IDLE);
  assign hs          = in_valid && in_ready;
  assign code_onehot = OUT_W'(onehot(MAX_IDX_W'(in_code)));

`ifdef DEC_TIMEOUT_EN
  logic err_q, err_d;
  logic to_clr;
  logic to_en;

  // Restart the age count on every accepted grant; age only unacked DRIVE cycles.
  assign to_clr = hs && in_v;
  assign to_en  = (state_q == DRIVE) && !dec_ack;

  dec_timeout_ctr #(
    .TO_CYC (TO_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (to_clr),
    .en_i     (to_en),
    .expire_o (expire)
  );

  // Sticky error: a new expiry beats a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (expire) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_err_clr;

  // Without the timeout a grant is held until ack and no error can occur.
  assign expire         = 1'b0;
  assign timeout_err    = 1'b0;
  assign unused_err_clr = err_clr;
`endif

  // Next-state logic for the IDLE/DRIVE controller and its registered outputs.
  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    valid_d = valid_q;
    none_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          if (in_v) begin
            dec_d   = code_onehot;
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = DRIVE;
          end else begin
            // "No request" code: report it, but in_code carries no meaning.
            none_d = 1'b1;
          end
        end
      end
      DRIVE: begin
        // Ack is checked first so an ack on the expiry cycle is a clean release.
        if (dec_ack || expire) begin
          dec_d   = '0;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        dec_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, all cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dec_q   <= '0;
      valid_q <= 1'b0;
      none_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      valid_q <= valid_d;
      none_q  <= none_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dec_out   = dec_q;
  assign dec_valid = valid_q;
  assign none_seen = none_q;
  assign dec_cnt   = cnt_q;

endmodule

// File: tb/tb_onehot_decoder_hs.sv
// Self-checking bench for onehot_decoder_hs. The reference model tracks the
// transaction view: whether a grant is outstanding, which line it is for, how
// many cycles it has gone unacknowledged, the decode count and the error flag.
// Timeout checks are active when DEC_TIMEOUT_EN is defined.
module tb_onehot_decoder_hs;

  localparam int IDX_W   = 2;
  localparam int OUT_W   = 4;
  localparam int TO_CYC  = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MOD = 256;
`ifdef DEC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IDX_W-1:0] in_code  = '0;
  logic             in_v     = 1'b0;
  logic [OUT_W-1:0] dec_out;
  logic             dec_valid;
  logic             dec_ack  = 1'b0;
  logic             none_seen;
  logic [CNT_W-1:0] dec_cnt;
  logic             timeout_err;
  logic             err_clr  = 1'b0;

  onehot_decoder_hs #(
    .IDX_W  (IDX_W),
    .TO_CYC (TO_CYC),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_code     (in_code),
    .in_v        (in_v),
    .dec_out     (dec_out),
    .dec_valid   (dec_valid),
    .dec_ack     (dec_ack),
    .none_seen   (none_seen),
    .dec_cnt     (dec_cnt),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  // ---------------- reference model state ----------------
  bit m_busy;   // a grant is outstanding
  int m_idx;    // line granted
  int m_age;    // unacked cycles of the outstanding grant
  int m_cnt;    // accepted decodes with in_v=1, modulo 2**CNT_W
  bit m_err;    // sticky timeout flag
  bit m_none;   // a no-request code was accepted on the last edge

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/dec_out"},     32'(dec_out),     m_busy ? (32'd1 << m_idx) : 32'd0);
    chk({tag, "/dec_valid"},   32'(dec_valid),   32'(m_busy));
    chk({tag, "/in_ready"},    32'(in_ready),    32'(!m_busy));
    chk({tag, "/none_seen"},   32'(none_seen),   32'(m_none));
    chk({tag, "/dec_cnt"},     32'(dec_cnt),     32'(m_cnt));
    chk({tag, "/timeout_err"}, 32'(timeout_err), 32'(m_err));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: applies inputs, predicts the next edge, checks after it.
  task automatic cycle(input string tag, input bit iv, input bit v, input int code,
                       input bit ack, input bit clr);
    bit set_err;
    in_valid = iv;
    in_v     = v;
    in_code  = IDX_W'(code);
    dec_ack  = ack;
    err_clr  = clr;
    set_err  = 1'b0;
    m_none   = 1'b0;
    if (!m_busy) begin
      if (iv) begin
        if (v) begin
          m_busy = 1'b1;
          m_idx  = code % OUT_W;
          m_age  = 0;
          m_cnt  = (m_cnt + 1) % CNT_MOD;
        end else begin
          m_none = 1'b1;
        end
      end
    end else if (ack) begin
      m_busy = 1'b0;
    end else begin
      m_age++;
      if (TO_EN && m_age >= TO_CYC) begin
        m_busy  = 1'b0;
        set_err = 1'b1;
      end
    end
    if (set_err) m_err = 1'b1;
    else if (TO_EN && clr) m_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_v     = 1'b0;
    in_code  = '0;
    dec_ack  = 1'b0;
    err_clr  = 1'b0;
  endtask

  // Asserts reset between clock edges and checks that it acts immediately.
  task automatic do_reset(input string tag);
    idle_inputs();
    rst = 1'b1;
    #1;
    m_busy = 1'b0; m_idx = 0; m_age = 0; m_cnt = 0; m_err = 1'b0; m_none = 1'b0;
    chk({tag, "/async_dec_out"},   32'(dec_out),   32'd0);
    chk({tag, "/async_dec_valid"}, 32'(dec_valid), 32'd0);
    chk({tag, "/async_dec_cnt"},   32'(dec_cnt),   32'd0);
    chk({tag, "/async_err"},       32'(timeout_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all({tag, "/released"});
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    m_busy = 1'b0; m_idx = 0; m_age = 0; m_cnt = 0; m_err = 1'b0; m_none = 1'b0;
    @(negedge clk);
    do_reset("por");

    // Reset in the middle of a grant of code 2.
    cycle("grant2", 1, 1, 2, 0, 0);
    chk("grant2_line", 32'(dec_out), 32'h4);
    cycle("grant2_hold", 0, 0, 0, 0, 0);
    do_reset("mid_drive");

    // Sweep every code, acking one cycle after dec_valid rises.
    for (int c = 0; c < OUT_W; c++) begin
      cycle("sweep_req", 1, 1, c, 0, 0);
      cycle("sweep_ack", 0, 0, 0, 1, 0);
    end
    chk("sweep_cnt", 32'(dec_cnt), 32'd4);

    // No-request code: one-cycle none_seen pulse, nothing else changes.
    cycle("none", 1, 0, 3, 0, 0);
    cycle("none_after", 0, 0, 0, 0, 0);
    cycle("none_idle", 0, 0, 0, 0, 0);

    // Back-pressure: code 3 waits while code 1 is held without ack.
    cycle("bp_grant1", 1, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle("bp_stall", 1, 1, 3, 0, 0);
    cycle("bp_ack", 1, 1, 3, 1, 0);
    cycle("bp_take3", 1, 1, 3, 0, 0);
    chk("bp_line3", 32'(dec_out), 32'h8);
    cycle("bp_ack3", 0, 0, 0, 1, 0);

`ifdef DEC_TIMEOUT_EN
    // Unacked grant expires after TO_CYC drive cycles.
    cycle("to_grant0", 1, 1, 0, 0, 0);
    for (int i = 0; i < TO_CYC; i++) cycle("to_wait", 0, 0, 0, 0, 0);
    chk("to_err_set", 32'(timeout_err), 32'd1);
    cycle("to_clear", 0, 0, 0, 0, 1);
    chk("to_err_clr", 32'(timeout_err), 32'd0);
    // Ack on the expiry cycle is a normal release.
    cycle("ackx_grant", 1, 1, 0, 0, 0);
    for (int i = 0; i < TO_CYC - 1; i++) cycle("ackx_wait", 0, 0, 0, 0, 0);
    cycle("ackx_ack", 0, 0, 0, 1, 0);
    chk("ackx_no_err", 32'(timeout_err), 32'd0);
    // Clear coinciding with a fresh expiry: the flag stays set.
    cycle("clrx_grant", 1, 1, 1, 0, 0);
    for (int i = 0; i < TO_CYC; i++) cycle("clrx_wait1", 0, 0, 0, 0, 0);
    cycle("clrx_grant2", 1, 1, 2, 0, 0);
    for (int i = 0; i < TO_CYC - 1; i++) cycle("clrx_wait2", 0, 0, 0, 0, 0);
    cycle("clrx_expire", 0, 0, 0, 0, 1);
    chk("clrx_err_kept", 32'(timeout_err), 32'd1);
    cycle("clrx_clear", 0, 0, 0, 0, 1);
`else
    // Without the timeout a grant outlives any wait and err_clr does nothing.
    cycle("hold_grant0", 1, 1, 0, 0, 0);
    for (int i = 0; i < 3 * TO_CYC; i++)
      cycle("hold_wait", 0, 0, 0, 0, bit'($urandom_range(0, 1)));
    chk("hold_line0", 32'(dec_out), 32'h1);
    cycle("hold_ack", 0, 0, 0, 1, 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cycle("rand",
            bit'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, OUT_W - 1)),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) == 0));
    end
    cycle("rand_drain", 0, 0, 0, 1, 1);

    // Decode counter wraps after 2**CNT_W accepted decodes.
    do_reset("wrap_rst");
    for (int i = 0; i < CNT_MOD; i++) begin
      cycle("wrap_req", 1, 1, int'($urandom_range(0, OUT_W - 1)), 0, 0);
      cycle("wrap_ack", 0, 0, 0, 1, 0);
    end
    chk("wrap_zero", 32'(dec_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_hs.md
Name: onehot_decoder_hs

Overview:
- Registered N-to-2^N decoder with handshake; the inverse of our 4-to-2 priority encoder.
- Accepts an encoded index plus its "code valid" bit (v) over a valid/ready interface.
- Drives a registered one-hot line and holds it until the consumer acknowledges it.
- Used to turn an arbitrated request index back into a per-line grant or strobe.

Parameters:
- IDX_W, 2, width of the encoded index. Output width OUT_W = 2**IDX_W is a derived localparam.
- TO_CYC, 8, timeout in cycles for an unacknowledged grant. Legal range 1..255.
- CNT_W, 8, width of the accepted-decode counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input code is presented.
- in_ready  out  1  block can accept a code this cycle.
- in_code  in  IDX_W  encoded index.
- in_v  in  1  code-valid bit. 0 means "no request".
- dec_out  out  OUT_W  registered one-hot decode.
- dec_valid  out  1  dec_out is asserted and awaiting ack.
- dec_ack  in  1  consumer acknowledge.
- none_seen  out  1  one-cycle pulse when a code with in_v=0 is accepted.
- dec_cnt  out  CNT_W  count of accepted decodes with in_v=1.
- timeout_err  out  1  sticky flag: a grant expired without ack.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE.
  - dec_out=0, dec_valid=0, none_seen=0, dec_cnt=0, timeout_err=0, timeout counter=0.
  - in_ready=1 after reset deasserts.
- States: IDLE and DRIVE. in_ready = (state==IDLE), combinational from state.
- A handshake occurs when in_valid && in_ready.
- IDLE, handshake with in_v=1:
  - Next cycle: dec_out = 1<<in_code, dec_valid=1, state=DRIVE, dec_cnt += 1.
  - dec_cnt wraps from 2**CNT_W-1 to 0.
  - Latency from handshake to dec_out is 1 cycle.
- IDLE, handshake with in_v=0:
  - dec_out stays 0. none_seen=1 for exactly one cycle. State stays IDLE and dec_cnt is unchanged.
  - in_code is ignored.
- IDLE, no handshake: all outputs hold; none_seen=0.
- DRIVE:
  - dec_out and dec_valid hold and input is stalled (in_ready=0).
  - dec_ack=1 clears dec_out and dec_valid next cycle and returns to IDLE.
  - dec_ack is ignored while dec_valid=0.
  - Peak throughput is one decode per 2 cycles.
- Timeout (only when compiled in):
  - Counter clears on entry to DRIVE and increments each DRIVE cycle without ack.
  - After TO_CYC consecutive DRIVE cycles with no ack, the next cycle clears dec_out and dec_valid, returns to IDLE and sets timeout_err.
  - dec_ack in the same cycle as expiry wins: normal release, no error.
- err_clr=1 clears timeout_err next cycle. If err_clr coincides with a new expiry, set wins.
- Invariant: dec_out is all-zero or exactly one-hot, and dec_out != 0 iff dec_valid.

Optional Feature:
- Macro: DEC_TIMEOUT_EN.
- Defined: timeout counter and timeout_err logic are present as described above.
- Undefined:
  - No counter is built; DRIVE holds indefinitely until dec_ack.
  - timeout_err is tied to 0 and err_clr is ignored.
  - Port list is unchanged.

Decomposition:
- Package dec_pkg holds:
  - typedef enum dec_state_t {IDLE, DRIVE}.
  - Default IDX_W constant.
  - Function onehot(idx) returning 1<<idx at OUT_W width.
- Sub-module dec_timeout_ctr (clear/enable in, expire pulse out, parameter TO_CYC).
  - Instantiated only under DEC_TIMEOUT_EN.

Test Plan:
- Reset mid-DRIVE: grant code 2 (dec_out=0100), assert rst for 1 cycle -> dec_out=0000, dec_valid=0, dec_cnt=0 immediately; in_ready=1 after release.
- Sweep in_code 0..3 with in_v=1, ack 1 cycle after each dec_valid -> dec_out = 0001, 0010, 0100, 1000 in turn, each 1 cycle after its handshake; dec_cnt=4.
- in_valid=1, in_v=0, in_code=3 -> none_seen high exactly 1 cycle, dec_out=0000, state stays IDLE, dec_cnt unchanged.
- Back-pressure: code 1 granted, present code 3 while DRIVE with no ack for 5 cycles -> in_ready=0, dec_out=0010 stable; after ack, code 3 is accepted and dec_out=1000.
- DEC_TIMEOUT_EN, TO_CYC=8:
  - Grant code 0 with no ack -> dec_out cleared and timeout_err=1 after 8 DRIVE cycles.
  - Repeat with ack on the expiry cycle -> no error.
  - err_clr coinciding with a new expiry -> timeout_err stays 1.
- dec_cnt wrap: 256 accepted decodes with in_v=1 -> dec_cnt returns to 0.
